// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: 16x32 register file plus ID/EX pipeline register
// Optional same-cycle write-back forwarding on the read ports: `define ID_WB_BYPASS_EN
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic        out_valid,
    output logic [31:0] pc_out,
    output logic [3:0]  cond,
    output logic [3:0]  opcode,
    output logic        i_bit,
    output logic        s_bit,
    output logic [3:0]  dest,
    output logic [11:0] imm12,
    output logic [31:0] rn_val,
    output logic [31:0] rm_val
);

    logic [31:0] rf [16];
    logic [3:0]  rn_idx;
    logic [3:0]  rm_idx;
    logic [31:0] rn_rd;
    logic [31:0] rm_rd;
    logic        capture;

    assign rn_idx  = instr_in[19:16];
    assign rm_idx  = instr_in[3:0];
    assign capture = in_valid && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
        end else if (wb_en) begin
            rf[wb_dest] <= wb_value;
        end
    end

    // Index 15 is the PC view; the stored r15 entry is writable but never read.
    function automatic logic [31:0] read_port(
        input logic [3:0]  idx,
        input logic [31:0] stored,
        input logic [31:0] pc,
        input logic        wen,
        input logic [3:0]  wdest,
        input logic [31:0] wval
    );
        logic [31:0] val;
        val = stored;
        if (idx == 4'd15) begin
            val = pc + 32'd2;
        end
`ifdef ID_WB_BYPASS_EN
        else if (wen && (wdest == idx)) begin
            val = wval;
        end
`else
        else if (wen && (wdest == idx) && 1'b0) begin
            val = wval;
        end
`endif
        return val;
    endfunction

    always_comb begin
        rn_rd = read_port(rn_idx, rf[rn_idx], pc_in, wb_en, wb_dest, wb_value);
        rm_rd = read_port(rm_idx, rf[rm_idx], pc_in, wb_en, wb_dest, wb_value);
    end

    // Stall outranks flush: a stalled slot holds even when a flush arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            pc_out    <= 32'd0;
            cond      <= 4'd0;
            opcode    <= 4'd0;
            i_bit     <= 1'b0;
            s_bit     <= 1'b0;
            dest      <= 4'd0;
            imm12     <= 12'd0;
            rn_val    <= 32'd0;
            rm_val    <= 32'd0;
        end else if (!stall) begin
            if (capture) begin
                out_valid <= 1'b1;
                pc_out    <= pc_in;
                cond      <= instr_in[31:28];
                opcode    <= instr_in[24:21];
                i_bit     <= instr_in[25];
                s_bit     <= instr_in[20];
                dest      <= instr_in[15:12];
                imm12     <= instr_in[11:0];
                rn_val    <= rn_rd;
                rm_val    <= rm_rd;
            end else begin
                out_valid <= 1'b0;
                pc_out    <= 32'd0;
                cond      <= 4'd0;
                opcode    <= 4'd0;
                i_bit     <= 1'b0;
                s_bit     <= 1'b0;
                dest      <= 4'd0;
                imm12     <= 12'd0;
                rn_val    <= 32'd0;
                rm_val    <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        i_bit;
    logic        s_bit;
    logic [3:0]  dest;
    logic [11:0] imm12;
    logic [31:0] rn_val;
    logic [31:0] rm_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .out_valid(out_valid), .pc_out(pc_out), .cond(cond), .opcode(opcode),
        .i_bit(i_bit), .s_bit(s_bit), .dest(dest), .imm12(imm12),
        .rn_val(rn_val), .rm_val(rm_val)
    );

    function automatic logic [31:0] mk(input logic [3:0] c, input logic i, input logic [3:0] op,
                                       input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] imm);
        return {c, 2'b00, i, op, s, rn, rd, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_in = 32'h0; instr_in = 32'h0; in_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'd0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || pc_out !== 32'd0 || rn_val !== 32'd0 || rm_val !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b pc=%h rn=%h rm=%h, want 0", out_valid, pc_out, rn_val, rm_val);
        end
        // a write strobe under reset must not land
        wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'hDEAD;
        tick();
        wb_en = 1'b0;
        #2 rst = 1'b0;
        instr_in = mk(4'h0, 1'b0, 4'h0, 1'b0, 4'd4, 4'd0, 12'h004); in_valid = 1'b1;
        tick();
        checks++;
        if (rn_val !== 32'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_write_suppressed: rn=%h valid=%b, want 0 / 1", rn_val, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_read_write();
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h0000_00AA;
        tick();
        wb_en = 1'b0;
        pc_in = 32'h40; instr_in = mk(4'hE, 1'b1, 4'h4, 1'b1, 4'd3, 4'd2, 12'h003); in_valid = 1'b1;
        tick();
        checks++;
        if (rn_val !== 32'hAA || rm_val !== 32'hAA || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rw_operands: rn=%h rm=%h valid=%b, want aa aa 1", rn_val, rm_val, out_valid);
        end
        checks++;
        if (cond !== 4'hE || opcode !== 4'h4 || i_bit !== 1'b1 || s_bit !== 1'b1 ||
            dest !== 4'd2 || imm12 !== 12'h003 || pc_out !== 32'h40) begin
            errors++;
            $display("FAIL rw_fields: cond=%h op=%h i=%b s=%b d=%h imm=%h pc=%h, want e 4 1 1 2 003 40",
                     cond, opcode, i_bit, s_bit, dest, imm12, pc_out);
        end
    endtask

    task automatic test_pc_read();
        pc_in = 32'h10; instr_in = mk(4'h1, 1'b0, 4'h2, 1'b0, 4'd15, 4'd1, 12'h00F); in_valid = 1'b1;
        tick();
        checks++;
        if (rn_val !== 32'h12 || rm_val !== 32'h12) begin
            errors++;
            $display("FAIL pc_read: rn=%h rm=%h, want 12 12", rn_val, rm_val);
        end
        wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h55; in_valid = 1'b0;
        tick();
        wb_en = 1'b0; in_valid = 1'b1;
        tick();
        checks++;
        if (rn_val !== 32'h12) begin
            errors++;
            $display("FAIL pc_read_after_r15_write: rn=%h, want 12", rn_val);
        end
        pc_in = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (rn_val !== 32'h1) begin
            errors++;
            $display("FAIL pc_read_wrap: rn=%h, want 1", rn_val);
        end
    endtask

    task automatic test_bypass();
        pc_in = 32'h20; instr_in = mk(4'h0, 1'b0, 4'h0, 1'b0, 4'd5, 4'd0, 12'h000); in_valid = 1'b1;
        wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h1234;
        tick();
        checks++;
`ifdef ID_WB_BYPASS_EN
        if (rn_val !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_same_cycle: rn=%h, want 1234", rn_val);
        end
`else
        if (rn_val !== 32'h0) begin
            errors++;
            $display("FAIL bypass_same_cycle: rn=%h, want 0", rn_val);
        end
`endif
        wb_en = 1'b0;
        tick();
        checks++;
        if (rn_val !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_reread: rn=%h, want 1234", rn_val);
        end
    endtask

    task automatic test_stall();
        pc_in = 32'h100; instr_in = mk(4'hA, 1'b0, 4'h3, 1'b0, 4'd3, 4'd6, 12'h005); in_valid = 1'b1;
        tick();
        stall = 1'b1; flush = 1'b1;
        pc_in = 32'h200; instr_in = mk(4'hB, 1'b1, 4'h9, 1'b1, 4'd7, 4'd8, 12'h007);
        wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            wb_en = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || pc_out !== 32'h100 || opcode !== 4'h3 ||
                dest !== 4'd6 || rn_val !== 32'hAA) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h op=%h d=%h rn=%h, want 1 100 3 6 aa",
                         k, out_valid, pc_out, opcode, dest, rn_val);
            end
        end
        stall = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h200 || opcode !== 4'h9 || cond !== 4'hB ||
            rn_val !== 32'h77 || rm_val !== 32'h77) begin
            errors++;
            $display("FAIL stall_release: valid=%b pc=%h op=%h cond=%h rn=%h rm=%h, want 1 200 9 b 77 77",
                     out_valid, pc_out, opcode, cond, rn_val, rm_val);
        end
    endtask

    task automatic test_flush();
        pc_in = 32'h300; instr_in = mk(4'hC, 1'b1, 4'h5, 1'b1, 4'd3, 4'd9, 12'hFFF); in_valid = 1'b1;
        flush = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || opcode !== 4'd0 || dest !== 4'd0 || pc_out !== 32'd0 || rn_val !== 32'd0) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b op=%h d=%h pc=%h rn=%h, want all 0",
                     out_valid, opcode, dest, pc_out, rn_val);
        end
        flush = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || opcode !== 4'd0 || dest !== 4'd0 || imm12 !== 12'd0) begin
            errors++;
            $display("FAIL invalid_bubble: valid=%b op=%h d=%h imm=%h, want all 0",
                     out_valid, opcode, dest, imm12);
        end
    endtask

    task automatic test_async_reset();
        pc_in = 32'h400; instr_in = mk(4'h2, 1'b0, 4'h1, 1'b0, 4'd3, 4'd1, 12'h005); in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || rn_val !== 32'hAA) begin
            errors++;
            $display("FAIL pre_reset_capture: valid=%b rn=%h, want 1 aa", out_valid, rn_val);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || rn_val !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b rn=%h, want 0 0", out_valid, rn_val);
        end
        #1 rst = 1'b0;
        instr_in = mk(4'h0, 1'b0, 4'h0, 1'b0, 4'd3, 4'd0, 12'h005);
        tick();
        checks++;
        if (rn_val !== 32'd0 || rm_val !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_r3_r5: rn=%h rm=%h, want 0 0", rn_val, rm_val);
        end
        instr_in = mk(4'h0, 1'b0, 4'h0, 1'b0, 4'd7, 4'd0, 12'h002);
        tick();
        checks++;
        if (rn_val !== 32'd0 || rm_val !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_r7_r2: rn=%h rm=%h, want 0 0", rn_val, rm_val);
        end
    endtask

    initial begin
        test_reset();
        test_read_write();
        test_pc_read();
        test_bypass();
        test_stall();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 pc_in  input  32  PC of the fetched instruction, from the fetch stage.
REQ-004 instr_in  input  32  fetched instruction word, from the fetch stage.
REQ-005 in_valid  input  1  pc_in/instr_in carry a real instruction this cycle.
REQ-006 stall  input  1  hold all ID/EX output registers.
REQ-007 flush  input  1  squash the instruction being captured; output a bubble.
REQ-008 wb_en  input  1  write-back strobe.
REQ-009 wb_dest  input  4  write-back register index.
REQ-010 wb_value  input  32  write-back data.
REQ-011 out_valid  output  1  ID/EX slot holds a real instruction.
REQ-012 pc_out  output  32  registered pc_in.
REQ-013 cond, opcode  output  4 each  registered instr[31:28], instr[24:21].
REQ-014 i_bit, s_bit  output  1 each  registered instr[25], instr[20].
REQ-015 dest  output  4  registered instr[15:12].
REQ-016 imm12  output  12  registered instr[11:0].
REQ-017 rn_val, rm_val  output  32 each  registered operands read at instr[19:16] and instr[3:0].

Function
REQ-018 Register file: 16 x 32-bit entries r0..r15, two combinational read ports, one write port.
REQ-019 Write port: on rising clk with wb_en=1, r[wb_dest] <= wb_value.
- Writes are independent of stall, flush and in_valid.
REQ-020 A read of index 15 returns pc_in + 32'd2 (modulo 2^32), never the stored r15 entry.
- r15 is still writable but never observable.
REQ-021 ID/EX register, every rising clk:
- stall=1: all outputs hold.
- else flush=1 or in_valid=0: out_valid<=0; all other outputs <=0.
- else: all fields captured from the current inputs and reads; out_valid<=1.
REQ-022 Priority: stall over flush; stall=1 with flush=1 holds the outputs.
REQ-023 Latency: instruction presented at edge N appears on the outputs after edge N+1 (one cycle).
REQ-024 Same-cycle write/read to the same index (not 15): behaviour is set by ID_WB_BYPASS_EN (REQ-029).
REQ-025 wb_en=1 while stall=1: the register file updates; held outputs do not change.

Reset
REQ-026 rst=1: out_valid=0 and all ID/EX outputs =0, immediately and asynchronously.
REQ-027 rst=1: r0..r15 cleared to 0.
REQ-028 rst=1: writes are suppressed. First capture and first write occur on the first rising clk after rst deasserts.

Configuration
REQ-029 Macro ID_WB_BYPASS_EN controls same-cycle write/read bypass.
- Defined: read ports forward wb_value when wb_en=1 and wb_dest equals the read index (not 15).
- Undefined: read ports return the stored (old) value; the write takes effect for later reads.

Verification
REQ-030 Reset, then write r3=0x0000_00AA; present instr with rn=3, rm=3, in_valid=1 -> next cycle rn_val=rm_val=0xAA, out_valid=1.
REQ-031 pc_in=0x10, instr rn=15 -> rn_val=0x12.
- Write r15=0x55, repeat -> rn_val is still 0x12.
REQ-032 Same-cycle write r5=0x1234 and read rn=5, with r5 previously 0:
- Macro defined -> rn_val=0x1234.
- Macro undefined -> rn_val=0; re-read next cycle -> 0x1234.
REQ-033 Capture instr A, then stall=1 for 3 cycles with new instr B and flush=1 -> outputs stay at A.
- Release with flush=0 -> B appears after one edge.
REQ-034 flush=1 with valid instr -> out_valid=0, opcode=0, dest=0 next cycle.
- in_valid=0 -> same bubble.
REQ-035 Assert rst mid-stream with out_valid=1 -> out_valid=0 and rn_val=0 before the next clk edge; all registers read 0 afterwards.
